// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format codes and the RV opcodes it decodes.
package imm_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    I    = 3'd1,
    S    = 3'd2,
    B    = 3'd3,
    U    = 3'd4,
    J    = 3'd5,
    Z    = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-side and execute-side valid/ready bundle of the immediate-decode stage.
interface imm_decode_stage_if #(parameter int XLEN = 32);

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [XLEN-1:0]      out_pc;
  logic [XLEN-1:0]      out_imm;
  imm_pkg::imm_fmt_e    out_fmt;
  logic [XLEN-1:0]      out_pc_rel;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_pc_rel
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_pc_rel
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational opcode -> {immediate, format} decode, extended to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  logic [31:0] imm32;

  always_comb begin
    fmt   = NONE;
    imm32 = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        fmt   = I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt   = I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        fmt   = S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = B;
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = J;
        imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        // funct3[2] selects the uimm CSR forms (csrrwi/csrrsi/csrrci)
        if (ENABLE_CSR && instr[14]) begin
          fmt   = Z;
          imm32 = {27'b0, instr[19:15]};
        end
      end
      default: ;
    endcase
  end

  // uimm has bit 31 clear, so sign extension also zero-extends it
  assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decode + pc-relative add at the input, 2-entry skid buffer.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  imm_decode_stage_if.slave   io
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_rel;
    imm_fmt_e        fmt;
  } entry_t;

  logic [XLEN-1:0] ext_imm;
  imm_fmt_e        ext_fmt;
  entry_t          in_e, out_q, skid_q;
  logic            out_v, skid_v;
  logic            in_fire, out_load;

  imm_extract #(.XLEN(XLEN), .ENABLE_CSR(ENABLE_CSR)) u_extract (
    .instr (io.in_instr),
    .imm   (ext_imm),
    .fmt   (ext_fmt)
  );

  assign in_e = '{instr: io.in_instr, pc: io.in_pc, imm: ext_imm,
                  pc_rel: io.in_pc + ext_imm, fmt: ext_fmt};

  // in_ready depends only on the skid flag, keeping out_ready off the upstream path
  assign in_fire  = io.in_valid && !skid_v;
  assign out_load = !out_v || io.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (out_load) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (in_fire) begin
        out_q  <= in_e;
        out_v  <= 1'b1;
      end else begin
        out_v  <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q <= in_e;
      skid_v <= 1'b1;
    end
  end

  assign io.in_ready   = !skid_v;
  assign io.out_valid  = out_v;
  assign io.out_instr  = out_q.instr;
  assign io.out_pc     = out_q.pc;
  assign io.out_imm    = out_q.imm;
  assign io.out_fmt    = out_q.fmt;
  assign io.out_pc_rel = out_q.pc_rel;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three configurations share one stimulus stream, each with its own scoreboard.
module tb_imm_decode_stage;
  import imm_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] rel;
    logic [2:0]  fmt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  int          checks = 0;
  int          failures = 0;
  int          last_stalls;
  exp_t        sbq [3][$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  // a: XLEN=32 CSR on, b: XLEN=64 CSR on, c: XLEN=32 CSR off
  imm_decode_stage_if #(.XLEN(32)) ifa ();
  imm_decode_stage_if #(.XLEN(64)) ifb ();
  imm_decode_stage_if #(.XLEN(32)) ifc ();

  imm_decode_stage #(.XLEN(32), .ENABLE_CSR(1'b1)) dut_a (.clk(clk), .rst(rst), .flush(flush), .io(ifa));
  imm_decode_stage #(.XLEN(64), .ENABLE_CSR(1'b1)) dut_b (.clk(clk), .rst(rst), .flush(flush), .io(ifb));
  imm_decode_stage #(.XLEN(32), .ENABLE_CSR(1'b0)) dut_c (.clk(clk), .rst(rst), .flush(flush), .io(ifc));

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;  assign ifc.in_valid = in_valid;
  assign ifa.in_instr = in_instr;  assign ifb.in_instr = in_instr;  assign ifc.in_instr = in_instr;
  assign ifa.in_pc    = in_pc[31:0]; assign ifb.in_pc = in_pc;     assign ifc.in_pc    = in_pc[31:0];
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifc.out_ready = out_ready;

  logic        act_v   [3];
  logic        act_rdy [3];
  logic [31:0] act_instr [3];
  logic [63:0] act_pc  [3];
  logic [63:0] act_imm [3];
  logic [63:0] act_rel [3];
  logic [2:0]  act_fmt [3];

  assign act_v[0] = ifa.out_valid; assign act_v[1] = ifb.out_valid; assign act_v[2] = ifc.out_valid;
  assign act_rdy[0] = ifa.in_ready; assign act_rdy[1] = ifb.in_ready; assign act_rdy[2] = ifc.in_ready;
  assign act_instr[0] = ifa.out_instr; assign act_instr[1] = ifb.out_instr; assign act_instr[2] = ifc.out_instr;
  assign act_pc[0]  = {32'b0, ifa.out_pc};     assign act_pc[1]  = ifb.out_pc;     assign act_pc[2]  = {32'b0, ifc.out_pc};
  assign act_imm[0] = {32'b0, ifa.out_imm};    assign act_imm[1] = ifb.out_imm;    assign act_imm[2] = {32'b0, ifc.out_imm};
  assign act_rel[0] = {32'b0, ifa.out_pc_rel}; assign act_rel[1] = ifb.out_pc_rel; assign act_rel[2] = {32'b0, ifc.out_pc_rel};
  assign act_fmt[0] = ifa.out_fmt; assign act_fmt[1] = ifb.out_fmt; assign act_fmt[2] = ifc.out_fmt;

  // known vectors with hand-derived results
  localparam int NV = 9;
  logic [31:0] tv_ins [NV] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h800000B7, 32'h3002D073,
                               32'h0010009B, 32'hFE112E23, 32'h0080006F, 32'h00000033};
  logic [63:0] tv_pc  [NV] = '{64'h0, 64'h100, 64'h200, 64'h0, 64'h10, 64'h20, 64'h30, 64'h40, 64'h50};
  logic [31:0] tv_imm_a [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h80000000, 32'h5,
                                 32'h0, 32'hFFFFFFFC, 32'h8, 32'h0};
  logic [2:0]  tv_fmt_a [NV] = '{I, B, U, U, Z, NONE, S, J, NONE};
  logic [31:0] tv_rel_a [NV] = '{32'hFFFFFFFF, 32'hFC, 32'h12345200, 32'h80000000, 32'h15,
                                 32'h20, 32'h2C, 32'h48, 32'h50};
  logic [63:0] tv_imm_b [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h12345000, 64'hFFFFFFFF80000000,
                                 64'h5, 64'h1, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h0};
  logic [2:0]  tv_fmt_b [NV] = '{I, B, U, U, Z, I, S, J, NONE};
  logic [31:0] tv_imm_c [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h80000000, 32'h0,
                                 32'h0, 32'hFFFFFFFC, 32'h8, 32'h0};
  logic [2:0]  tv_fmt_c [NV] = '{I, B, U, U, NONE, NONE, S, J, NONE};

  function automatic void model(input logic [31:0] w, input bit x64, input bit csr,
                                output logic [63:0] im, output logic [2:0] f);
    im = '0;
    f  = NONE;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin f = I; im = {{52{w[31]}}, w[31:20]}; end
      7'h1B: if (x64) begin f = I; im = {{52{w[31]}}, w[31:20]}; end
      7'h23: begin f = S; im = {{52{w[31]}}, w[31:25], w[11:7]}; end
      7'h63: begin f = B; im = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
      7'h37, 7'h17: begin f = U; im = {{32{w[31]}}, w[31:12], 12'b0}; end
      7'h6F: begin f = J; im = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
      7'h73: if (csr && w[14]) begin f = Z; im = {59'b0, w[19:15]}; end
      default: ;
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] ins, input logic [63:0] pc);
    exp_t e;
    logic [63:0] im;
    logic [2:0] f;
    for (int k = 0; k < 3; k++) begin
      model(ins, k == 1, k != 2, im, f);
      e.instr = ins;
      e.fmt   = f;
      if (k == 1) begin
        e.pc = pc; e.imm = im; e.rel = pc + im;
      end else begin
        e.pc = {32'b0, pc[31:0]}; e.imm = {32'b0, im[31:0]}; e.rel = {32'b0, pc[31:0] + im[31:0]};
      end
      sbq[k].push_back(e);
    end
  endtask

  task automatic clear_sb();
    for (int k = 0; k < 3; k++) sbq[k].delete();
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    last_stalls = 0;
    forever begin
      @(negedge clk);
      if (ifa.in_ready) break;
      last_stalls++;
      if (last_stalls > 50) begin
        checks++; failures++;
        $display("FAIL send_timeout instr=%h in_ready stayed 0", ins);
        break;
      end
    end
    if (last_stalls <= 50) push_exp(ins, pc);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // scoreboard: every output transfer pops and compares in order
  always @(negedge clk) begin
    if (!rst && !flush && out_ready) begin
      for (int k = 0; k < 3; k++) begin
        if (act_v[k]) begin
          checks++;
          if (sbq[k].size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected dut%0d got instr=%h imm=%h, required no output", k, act_instr[k], act_imm[k]);
          end else begin
            mon_e = sbq[k].pop_front();
            if (act_instr[k] !== mon_e.instr || act_pc[k] !== mon_e.pc || act_imm[k] !== mon_e.imm ||
                act_rel[k] !== mon_e.rel || act_fmt[k] !== mon_e.fmt) begin
              failures++;
              $display("FAIL sb_entry dut%0d got instr=%h pc=%h imm=%h rel=%h fmt=%0d, required instr=%h pc=%h imm=%h rel=%h fmt=%0d",
                       k, act_instr[k], act_pc[k], act_imm[k], act_rel[k], act_fmt[k],
                       mon_e.instr, mon_e.pc, mon_e.imm, mon_e.rel, mon_e.fmt);
            end
          end
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_v[k] !== 1'b0 || act_rdy[k] !== 1'b1 || act_instr[k] !== '0 || act_pc[k] !== '0 ||
          act_imm[k] !== '0 || act_rel[k] !== '0 || act_fmt[k] !== '0) begin
        failures++;
        $display("FAIL %s dut%0d got v=%b rdy=%b instr=%h imm=%h rel=%h fmt=%0d, required v=0 rdy=1 data=0",
                 tag, k, act_v[k], act_rdy[k], act_instr[k], act_imm[k], act_rel[k], act_fmt[k]);
      end
    end
  endtask

  task automatic drain_and_check_empty(input string tag);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sbq[k].size() != 0) begin
        failures++;
        $display("FAIL %s dut%0d got %0d entries outstanding, required 0", tag, k, sbq[k].size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_known_vectors();
    out_ready = 1'b1;
    for (int t = 0; t < NV; t++) begin
      send(tv_ins[t], tv_pc[t]);
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.out_imm !== tv_imm_a[t] || ifa.out_fmt !== tv_fmt_a[t] ||
          ifa.out_pc_rel !== tv_rel_a[t]) begin
        failures++;
        $display("FAIL vec%0d_x32 got v=%b imm=%h fmt=%0d rel=%h, required v=1 imm=%h fmt=%0d rel=%h",
                 t, ifa.out_valid, ifa.out_imm, ifa.out_fmt, ifa.out_pc_rel, tv_imm_a[t], tv_fmt_a[t], tv_rel_a[t]);
      end
      checks++;
      if (ifb.out_imm !== tv_imm_b[t] || ifb.out_fmt !== tv_fmt_b[t]) begin
        failures++;
        $display("FAIL vec%0d_x64 got imm=%h fmt=%0d, required imm=%h fmt=%0d",
                 t, ifb.out_imm, ifb.out_fmt, tv_imm_b[t], tv_fmt_b[t]);
      end
      checks++;
      if (ifc.out_imm !== tv_imm_c[t] || ifc.out_fmt !== tv_fmt_c[t]) begin
        failures++;
        $display("FAIL vec%0d_nocsr got imm=%h fmt=%0d, required imm=%h fmt=%0d",
                 t, ifc.out_imm, ifc.out_fmt, tv_imm_c[t], tv_fmt_c[t]);
      end
      @(posedge clk); #1;
    end
    drain_and_check_empty("known_drain");
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      send($urandom, {32'h0, $urandom} & 64'hFFFF_FFFC);
      stalls += last_stalls;
    end
    checks++;
    if (stalls != 0) begin
      failures++;
      $display("FAIL b2b_throughput got %0d stall cycles, required 0", stalls);
    end
    drain_and_check_empty("b2b_drain");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'h00100093, 64'h1000);
    send(32'h00200113, 64'h1004);
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 64'h1008;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1 || ifa.out_instr !== 32'h00100093) begin
        failures++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b instr=%h, required rdy=0 v=1 instr=00100093",
                 c, ifa.in_ready, ifa.out_valid, ifa.out_instr);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    fork
      send(32'h00300193, 64'h1008);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (ifa.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_gap%0d got out_valid=%b, required 1", c, ifa.out_valid);
        end
      end
    join
    drain_and_check_empty("bp_drain");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h00400213, 64'h2000);
    send(32'h00500293, 64'h2004);
    in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 64'h2008; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    clear_sb();
    @(negedge clk);
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifb.out_valid !== 1'b0 || ifb.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full got v=%b rdy=%b, required v=0 rdy=1", ifa.out_valid, ifa.in_ready);
    end
    // input offered and accepted in the flush cycle must vanish
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 64'h200C; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (ifa.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_accept_rdy got in_ready=%b, required 1", ifa.in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.out_valid !== 1'b0 || ifc.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard got out_valid=%b, required 0", ifa.out_valid);
    end
    @(posedge clk); #1;
    send(32'h00800413, 64'h2010);
    drain_and_check_empty("flush_drain");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'hFFF00093, 64'h3000);
    send(32'h800000B7, 64'h3004);
    rst = 1'b1;
    @(posedge clk); #1;
    clear_sb();
    @(negedge clk);
    check_reset_values("reset_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h00100093, 64'h3008);
    drain_and_check_empty("reset_mid_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
